dbncn: RTL and testbench
========================

Name: dbncn

Overview:
- Multi-channel, parametrised button/switch debouncer for board buttons and DIP switches.
- Provides per-channel:
  - debounced level;
  - single-cycle press and release pulses;
  - per-channel polarity;
  - a sticky press-event register with software clear.
- `irq` is the OR of the pending press events and is intended for the interrupt controller or an IO register.

Parameters:
- `NUM_CH`, 4: number of independent input channels (1..32).
- `CNT_W`, 17: stability counter width; debounce period is 2^CNT_W clk cycles (50 MHz: 2.6 ms).
- `POL`, {NUM_CH{1'b1}}: per-channel polarity mask; bit=1 means the input is active high, bit=0 means active low.
- `RPT_DLY_W`, 25: auto-repeat initial delay width, 2^RPT_DLY_W cycles (used only with the macro).
- `RPT_PER_W`, 23: auto-repeat period width, 2^RPT_PER_W cycles (used only with the macro).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous reset, active high.
- `btn_in`, in, NUM_CH: raw, asynchronous, bouncy inputs.
- `btn_out`, out, NUM_CH: debounced level, normalised to active high.
- `pressed`, out, NUM_CH: 1-cycle pulse on each debounced 0->1 transition (plus repeats, see macro).
- `released`, out, NUM_CH: 1-cycle pulse on each debounced 1->0 transition.
- `evt`, out, NUM_CH: sticky press-event flags.
- `evt_clr`, in, NUM_CH: clear mask for `evt`, sampled every cycle.
- `irq`, out, 1: |evt.

Behaviour:
- **Reset** (async assert, removed synchronously by the surrounding reset logic):
  - sync flops, counters, `btn_out`, `pressed`, `released`, `evt` all go to 0;
  - `irq` goes to 0.
- **Per channel** c, with p = POL[c] ? btn_in[c] : ~btn_in[c]:
  - Two-flop synchroniser: s0 <= p; s1 <= s0.
  - Counter cnt[CNT_W-1:0]:
    - if s1 == state: cnt <= 0;
    - else if cnt == all-ones: cnt <= 0 and state <= ~state;
    - else: cnt <= cnt + 1.
  - Any bounce back to the current state while counting restarts the counter from 0.
- **Latency**: if p changes and stays stable, take edge 1 as the first edge sampling the new level into s0. Then `btn_out` changes at edge 2^CNT_W + 2.
- **Pulses**:
  - `pressed`/`released` are registered and assert in the same cycle `btn_out` changes; high for exactly 1 cycle.
  - Never both high on one channel in the same cycle.
- **evt[c]**:
  - set by `pressed[c]`;
  - cleared when evt_clr[c] = 1;
  - simultaneous set and clear on the same channel: set wins.
- **irq**: combinational OR of `evt`, no extra latency.
- **Input active at reset release**: the debounced level rises 2^CNT_W + 2 edges later with a `pressed` pulse. This is a real press event, not suppressed.
- **Channel independence**: channels are fully independent; simultaneous events on several channels each produce their own pulses.

Optional Feature:
- **Macro**: DBNCN_REPEAT_EN.
- **Defined**: per channel, while btn_out[c] = 1:
  - a repeat counter emits an extra `pressed[c]` pulse (and `evt` set) first 2^RPT_DLY_W cycles after the initial press, then every 2^RPT_PER_W cycles;
  - the counter clears on release or reset;
  - `released` is unaffected.
- **Undefined**: no repeat logic is synthesised; `pressed` fires once per press; RPT_* parameters are ignored.

Decomposition:
- Shared include `dbncn_pkg`: default widths (CNT_W 17, RPT_DLY_W 25, RPT_PER_W 23) and NUM_CH limit constant.
- Sub-module `dbncn_ch`: one channel, containing synchroniser, counter, state, pulses and optional repeat counter. Instantiated NUM_CH times via a generate loop.
- Top-level `dbncn` holds only the `evt` register and `irq`.

Test Plan (CNT_W=3, NUM_CH=4, POL=4'b0111, RPT_DLY_W=5, RPT_PER_W=4):
- **Reset**: hold `rst` with all inputs toggling -> all outputs 0; deassert with btn_in = 4'b1000 (ch3 inactive, active low) -> no pulses for 20 cycles.
- **Clean press**: ch0 0->1 clean -> `btn_out[0]` and `pressed[0]` high at edge 10 (2^3 + 2), `pressed[0]` low at edge 11; `evt[0]` = 1; `irq` = 1.
- **Bounce**: ch1 toggles every 3 cycles for 30 cycles, then holds 1 -> no output change during bouncing; `btn_out[1]` rises 10 edges after the last edge; exactly 1 `pressed` pulse.
- **Release and active-low**:
  - ch3 driven 1->0 -> `pressed[3]` after 10 edges;
  - drive back to 1 -> `released[3]`; `evt[3]` remains 1.
- **Clear race**: assert `evt_clr[0]` in the same cycle as a new `pressed[0]` -> `evt[0]` stays 1; next cycle clear alone -> `evt[0]` = 0; `irq` drops when all clear.
- **Repeat (macro defined)**: hold ch2 active for 100 cycles -> `pressed[2]` pulses at press, +32, then every +16; none after release. With the macro undefined -> single pulse.

Source files
------------

// File: rtl/dbncn_pkg.sv
// Shared defaults for the dbncn multi-channel debouncer.
// The optional auto-repeat feature is enabled by defining DBNCN_REPEAT_EN.
package dbncn_pkg;

    localparam int CNT_W_DEF     = 17;
    localparam int RPT_DLY_W_DEF = 25;
    localparam int RPT_PER_W_DEF = 23;
    localparam int MAX_CH        = 32;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dbncn_ch.sv
// One debouncer channel: polarity fold, two-flop synchroniser, stability counter,
// edge pulses and (with DBNCN_REPEAT_EN) a held-button auto-repeat counter.
module dbncn_ch
    import dbncn_pkg::*;
#(
    parameter int   CNT_W     = CNT_W_DEF,
    parameter logic POL       = 1'b1,
    parameter int   RPT_DLY_W = RPT_DLY_W_DEF,
    parameter int   RPT_PER_W = RPT_PER_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic pressed,
    output logic released
);

    logic             p;
    logic             s0;
    logic             s1;
    logic [CNT_W-1:0] cnt;
    logic             flip;
    logic             rpt_fire;

    assign p    = POL ? btn_in : ~btn_in;
    assign flip = (s1 != level) && (&cnt);

    // Counter only runs while the synchronised input disagrees with the debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0    <= 1'b0;
            s1    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s0 <= p;
            s1 <= s0;
            if (s1 == level) begin
                cnt <= '0;
            end else if (&cnt) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DBNCN_REPEAT_EN
    localparam int RPT_W = max_w(RPT_DLY_W, RPT_PER_W);
    localparam logic [RPT_W-1:0] DLY_MAX = RPT_W'({RPT_DLY_W{1'b1}});
    localparam logic [RPT_W-1:0] PER_MAX = RPT_W'({RPT_PER_W{1'b1}});

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;

    // A release on this same edge takes priority, so a repeat never coincides with released
    assign rpt_fire = level && !flip &&
                      (rpt_first ? (rpt_cnt == DLY_MAX) : (rpt_cnt == PER_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!level || flip) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= (flip && !level) || rpt_fire;
            released <= flip && level;
        end
    end

endmodule

// File: rtl/dbncn.sv
// Multi-channel debouncer top: per-channel debouncers plus sticky press events and irq.
// Define DBNCN_REPEAT_EN to add auto-repeat press pulses while a button is held.
module dbncn
    import dbncn_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                CNT_W     = CNT_W_DEF,
    parameter logic [NUM_CH-1:0] POL       = {NUM_CH{1'b1}},
    parameter int                RPT_DLY_W = RPT_DLY_W_DEF,
    parameter int                RPT_PER_W = RPT_PER_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_out,
    output logic [NUM_CH-1:0] pressed,
    output logic [NUM_CH-1:0] released,
    output logic [NUM_CH-1:0] evt,
    input  logic [NUM_CH-1:0] evt_clr,
    output logic              irq
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dbncn_ch #(
            .CNT_W     (CNT_W),
            .POL       (POL[c]),
            .RPT_DLY_W (RPT_DLY_W),
            .RPT_PER_W (RPT_PER_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_in   (btn_in[c]),
            .level    (btn_out[c]),
            .pressed  (pressed[c]),
            .released (released[c])
        );
    end

    // A new press overrides a clear issued in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt <= '0;
        end else begin
            evt <= (evt & ~evt_clr) | pressed;
        end
    end

    assign irq = |evt;

endmodule

// File: tb/tb_dbncn.sv
// Directed self-checking bench for dbncn (CNT_W=3, NUM_CH=4, POL=4'b0111).
// Repeat expectations follow DBNCN_REPEAT_EN when the bench is built with it.
module tb_dbncn;

`ifdef DBNCN_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] btn_out;
    logic [3:0] pressed;
    logic [3:0] released;
    logic [3:0] evt;
    logic [3:0] evt_clr;
    logic       irq;

    int vecs;
    int errs;
    int press_cnt [4];
    int both_cnt;
    int n1;

    dbncn #(
        .NUM_CH    (4),
        .CNT_W     (3),
        .POL       (4'b0111),
        .RPT_DLY_W (5),
        .RPT_PER_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_out  (btn_out),
        .pressed  (pressed),
        .released (released),
        .evt      (evt),
        .evt_clr  (evt_clr),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse bookkeeping sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[c]) press_cnt[c]++;
                if (pressed[c] && released[c]) both_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_p;
        vecs    = 0;
        errs    = 0;
        rst     = 1'b1;
        btn_in  = 4'b0000;
        evt_clr = 4'b0000;

        // Reset held with toggling inputs
        for (int i = 0; i < 6; i++) begin
            btn_in  = 4'($urandom);
            evt_clr = 4'($urandom);
            tick(1);
            check_output("reset_outs", {btn_out, pressed, released, evt, 3'b000, irq}, 32'h0);
        end
        evt_clr = 4'b0000;
        btn_in  = 4'b1000;
        rst     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_output("post_reset_pulses", {pressed, released}, 32'h0);
        end
        check_output("post_reset_level", btn_out, 32'h0);

        // Clean press on ch0
        btn_in[0] = 1'b1;
        tick(9);
        check_output("ch0_edge9_level", btn_out[0], 32'h0);
        tick(1);
        check_output("ch0_edge10_level", btn_out[0], 32'h1);
        check_output("ch0_edge10_pressed", pressed[0], 32'h1);
        check_output("ch0_edge10_evt", evt[0], 32'h0);
        tick(1);
        check_output("ch0_edge11_pressed", pressed[0], 32'h0);
        check_output("ch0_edge11_evt", evt[0], 32'h1);
        check_output("ch0_edge11_irq", irq, 32'h1);

        // Bouncing ch1
        n1 = press_cnt[1];
        for (int i = 0; i < 10; i++) begin
            btn_in[1] = ~btn_in[1];
            tick(3);
            check_output("ch1_bounce_level", btn_out[1], 32'h0);
            check_output("ch1_bounce_pressed", pressed[1], 32'h0);
        end
        btn_in[1] = 1'b1;
        tick(9);
        check_output("ch1_edge9_level", btn_out[1], 32'h0);
        tick(1);
        check_output("ch1_edge10_level", btn_out[1], 32'h1);
        check_output("ch1_edge10_pressed", pressed[1], 32'h1);
        tick(2);
        check_output("ch1_press_count", press_cnt[1] - n1, 32'h1);
        check_output("ch1_evt", evt[1], 32'h1);

        // Active-low ch3 press and release
        btn_in[3] = 1'b0;
        tick(10);
        check_output("ch3_press", {btn_out[3], pressed[3]}, 32'h3);
        tick(1);
        check_output("ch3_press_end", pressed[3], 32'h0);
        btn_in[3] = 1'b1;
        tick(9);
        check_output("ch3_rel_edge9", btn_out[3], 32'h1);
        tick(1);
        check_output("ch3_release", {btn_out[3], pressed[3], released[3]}, 32'h1);
        tick(1);
        check_output("ch3_release_end", released[3], 32'h0);
        check_output("ch3_evt_sticky", evt[3], 32'h1);

        // Clear racing a new press on ch0
        btn_in[1:0] = 2'b00;
        tick(10);
        check_output("ch01_release", released[1:0], 32'h3);
        check_output("ch0_evt_before_race", evt[0], 32'h1);
        tick(1);
        btn_in[0] = 1'b1;
        tick(10);
        check_output("ch0_repress", pressed[0], 32'h1);
        evt_clr = 4'b0001;
        tick(1);
        check_output("ch0_race_set_wins", evt[0], 32'h1);
        tick(1);
        check_output("ch0_clear_alone", evt[0], 32'h0);
        check_output("irq_others_pending", irq, 32'h1);
        evt_clr = 4'b1111;
        tick(1);
        check_output("evt_all_clear", evt, 32'h0);
        check_output("irq_all_clear", irq, 32'h0);
        evt_clr   = 4'b0000;
        btn_in[0] = 1'b0;
        tick(12);

        // Held ch2: auto-repeat only when the feature is built in
        btn_in[2] = 1'b1;
        tick(10);
        check_output("ch2_press", {btn_out[2], pressed[2]}, 32'h3);
        for (int k = 1; k <= 150; k++) begin
            tick(1);
            exp_p = RPT_ON && (k >= 32) && (k < 110) && (((k - 32) % 16) == 0);
            check_output($sformatf("ch2_pressed_k%0d", k), pressed[2], 32'(exp_p));
            check_output($sformatf("ch2_released_k%0d", k), released[2], 32'(k == 110));
            if (k == 100) btn_in[2] = 1'b0;
        end
        check_output("ch2_evt", evt[2], 32'h1);
        check_output("never_both_pulses", both_cnt, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
